avatar_motion: RTL and testbench
================================

# avatar_motion

Consumer end of the controller action interface. Takes the 2-bit action code from the button-decoding FSM and turns it into avatar motion: a registered horizontal position and a vertical jump arc. It sits between the controller FSM and the renderer. It advances once per frame-enable `tick`, and each airborne episode allows one double jump.

## Interface
Parameters:
- `X_W`, default 8: width of `x_pos`.
- `Y_W`, default 6: width of `y_pos`.
- `X_MAX`, default 159: largest x value; the next run step wraps x to 0. Requires `X_MAX` ≤ 2^X_W−1.
- `JUMP_H`, default 8: rise ticks for a normal jump. Requires `JUMP_H` ≥ 1.
- `DJUMP_EXTRA`, default 4: rise ticks added by a double jump. Requires `DJUMP_EXTRA` ≥ 1 and `JUMP_H`+`DJUMP_EXTRA` ≤ 2^Y_W−1.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `tick`, in, 1: frame enable. State advances only on edges where `tick`=1.
- `action`, in, 2: 00 STAND, 01 JUMP, 10 DJUMP, 11 RUN.
- `x_pos`, out, X_W: horizontal position, registered.
- `y_pos`, out, Y_W: height above ground, registered.
- `phase`, out, 2: 00 GROUND, 01 RISE, 10 FALL. 11 is unused.
- `airborne`, out, 1: registered; high when `phase` ≠ GROUND.
- `landed`, out, 1: one-cycle pulse on the cycle after the FALL→GROUND transition.

## Operation
Internal state:
- `phase`.
- `rise_left`, Y_W bits.
- `dj_used`, 1 bit.

Reset values (next edge with `reset`=1, any phase): `x_pos`=0, `y_pos`=0, `phase`=GROUND, `rise_left`=0, `dj_used`=0, `airborne`=0, `landed`=0. `reset` has priority over `tick`.

When `tick`=0: all state holds and `landed`=0. `action` is sampled only when `tick`=1.

Horizontal rule:
- RUN in any phase: `x_pos` increments, or goes to 0 if it equals `X_MAX`.
- Any other action: `x_pos` holds.

Vertical FSM, evaluated on `tick`=1:
- **GROUND**
  - JUMP: `y_pos`←1, `rise_left`←`JUMP_H`−1. Go to RISE, or to FALL if that value is 0.
  - DJUMP, RUN, STAND: stay in GROUND.
- **RISE**
  - `y_pos`+1 on every tick in this phase.
  - DJUMP with `dj_used`=0: `rise_left`←`rise_left`−1+`DJUMP_EXTRA`, `dj_used`←1.
  - Otherwise: `rise_left`←`rise_left`−1.
  - Go to FALL when the new `rise_left` is 0.
- **FALL**
  - DJUMP with `dj_used`=0: `y_pos`+1, `dj_used`←1, `rise_left`←`DJUMP_EXTRA`−1. Go to RISE, or stay in FALL if that value is 0.
  - Otherwise: `y_pos`−1. If `y_pos` was 1, go to GROUND with `dj_used`←0 and `landed`←1.
- JUMP while airborne is ignored; it behaves as STAND for the vertical FSM.
- A second DJUMP in the same airborne episode is ignored.
- Encoding 11 on `phase` never occurs. If reached, return to GROUND with `y_pos`=0.

Consequences:
- Without a double jump: peak `y_pos`=`JUMP_H`, reached on rise tick `JUMP_H`; ground-to-ground takes 2·`JUMP_H` ticks.
- A double jump during RISE raises the peak to `JUMP_H`+`DJUMP_EXTRA`.
- The `y_pos` range is guaranteed by the parameter constraint; no saturation logic is needed.

## Timing
- All outputs are registered. The effect of a tick on edge N is visible after edge N; combinational latency is 0.
- `landed` is high for exactly one clk cycle, the one after the landing tick edge, regardless of `tick` spacing.
- Reset mid-air takes effect on that edge: next cycle shows `y_pos`=0, GROUND, and no `landed` pulse.
- RUN and the vertical update are concurrent, so x and y can both change on the same tick.

## Structure
- Package `motion_pkg` holds:
  - `action_t` enum, logic [1:0]: A_STAND=00, A_JUMP=01, A_DJUMP=10, A_RUN=11. The encoding matches the controller FSM's action output.
  - `phase_t` enum, logic [1:0]: P_GROUND, P_RISE, P_FALL.
- One sub-module, `x_wrap_counter`: an enabled modulo-(`X_MAX`+1) counter parameterised by `X_W` and `X_MAX`.
- The vertical FSM and the rise/`y_pos` counters live in `avatar_motion`.

## Test plan
Defaults apply unless stated; the bench asserts `tick` every cycle.
1. **Run:** reset, then 5 ticks of RUN → `x_pos`=5, `y_pos`=0, `phase`=GROUND, `airborne`=0.
2. **Normal jump:** one tick of JUMP, then STAND → `y_pos` = 1..8 on ticks 1–8, then 7..0 on ticks 9–16. `phase` is FALL from after tick 8, `landed` pulses once after tick 16, and `airborne` is 0 afterwards.
3. **Double jump during rise:** JUMP, then DJUMP on tick 3 → peak `y_pos`=12 after tick 12, ground after tick 24.
4. **Ignored actions:**
   - DJUMP on GROUND → nothing moves.
   - JUMP while airborne → arc unchanged.
   - DJUMP on tick 3 and again on tick 5 → only the first is honoured (peak 12).
5. **Double jump from FALL, plus wrap:**
   - DJUMP at `y_pos`=6 in FALL → `y_pos` 7,8,9,10, then falls.
   - With `x_pos`=159, a RUN tick → `x_pos`=0.
   - RUN while airborne changes x and y on the same tick.
6. **Reset and enable:**
   - `reset` at `y_pos`=5 mid-rise → next cycle `y_pos`=0, GROUND, `landed`=0.
   - `tick`=0 for 10 cycles with RUN applied → `x_pos` and `y_pos` unchanged.

Source files
------------

// File: rtl/motion_pkg.sv
// motion_pkg: shared types for the avatar motion slice.
//   action_t : controller action code (matches the controller FSM's action output)
//   phase_t  : vertical motion phase reported to the renderer
package motion_pkg;

    typedef enum logic [1:0] {
        A_STAND = 2'b00,
        A_JUMP  = 2'b01,
        A_DJUMP = 2'b10,
        A_RUN   = 2'b11
    } action_t;

    typedef enum logic [1:0] {
        P_GROUND = 2'b00,
        P_RISE   = 2'b01,
        P_FALL   = 2'b10
    } phase_t;

endpackage

// File: rtl/x_wrap_counter.sv
// x_wrap_counter: enabled modulo-(X_MAX+1) counter for the horizontal position.
//   clk     : clock
//   reset   : synchronous active-high reset, clears the count
//   en_i    : advance by one when high
//   count_o : registered count, wraps from X_MAX to 0
module x_wrap_counter #(
    parameter int unsigned X_W   = 8,
    parameter int unsigned X_MAX = 159
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en_i,
    output logic [X_W-1:0] count_o
);

    localparam logic [X_W-1:0] MAX_VAL = X_W'(X_MAX);

    logic [X_W-1:0] count_q;
    logic [X_W-1:0] count_d;

    // Next count: wrap at the top of the range.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            if (count_q == MAX_VAL) begin
                count_d = '0;
            end else begin
                count_d = count_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/avatar_motion.sv
// avatar_motion: turns controller action codes into a horizontal position and
// a jump arc with one double jump per airborne episode. Advances on tick only.
//   clk, reset : clock, synchronous active-high reset
//   tick       : frame enable
//   action     : 00 STAND, 01 JUMP, 10 DJUMP, 11 RUN
//   x_pos      : registered horizontal position (wraps past X_MAX)
//   y_pos      : registered height above ground
//   phase      : 00 GROUND, 01 RISE, 10 FALL
//   airborne   : registered, high when phase is not GROUND
//   landed     : one-cycle pulse after the landing tick
module avatar_motion
    import motion_pkg::*;
#(
    parameter int unsigned X_W         = 8,
    parameter int unsigned Y_W         = 6,
    parameter int unsigned X_MAX       = 159,
    parameter int unsigned JUMP_H      = 8,
    parameter int unsigned DJUMP_EXTRA = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic [1:0]     action,
    output logic [X_W-1:0] x_pos,
    output logic [Y_W-1:0] y_pos,
    output logic [1:0]     phase,
    output logic           airborne,
    output logic           landed
);

    localparam logic [Y_W-1:0] JUMP_RISE_INIT = Y_W'(JUMP_H - 1);
    localparam logic [Y_W-1:0] DJ_EXTRA       = Y_W'(DJUMP_EXTRA);
    localparam logic [Y_W-1:0] DJ_RISE_INIT   = Y_W'(DJUMP_EXTRA - 1);

    action_t        act;
    phase_t         phase_q,     phase_d;
    logic [Y_W-1:0] y_q,         y_d;
    logic [Y_W-1:0] rise_left_q, rise_left_d;
    logic           dj_used_q,   dj_used_d;
    logic           airborne_q,  airborne_d;
    logic           landed_q,    landed_d;
    logic [Y_W-1:0] rise_next;
    logic           dj_ok;

    assign act   = action_t'(action);
    assign dj_ok = (act == A_DJUMP) && !dj_used_q;

    // Horizontal position: RUN advances in any phase, concurrent with vertical.
    x_wrap_counter #(
        .X_W   (X_W),
        .X_MAX (X_MAX)
    ) u_x_wrap_counter (
        .clk     (clk),
        .reset   (reset),
        .en_i    (tick && (act == A_RUN)),
        .count_o (x_pos)
    );

    // Vertical FSM next-state and counters; JUMP while airborne acts as STAND.
    always_comb begin
        phase_d     = phase_q;
        y_d         = y_q;
        rise_left_d = rise_left_q;
        dj_used_d   = dj_used_q;
        landed_d    = 1'b0;
        rise_next   = rise_left_q - Y_W'(1);

        if (tick) begin
            case (phase_q)
                P_GROUND: begin
                    if (act == A_JUMP) begin
                        y_d         = Y_W'(1);
                        rise_left_d = JUMP_RISE_INIT;
                        phase_d     = (JUMP_RISE_INIT == '0) ? P_FALL : P_RISE;
                    end
                end
                P_RISE: begin
                    y_d = y_q + Y_W'(1);
                    if (dj_ok) begin
                        rise_next = rise_left_q - Y_W'(1) + DJ_EXTRA;
                        dj_used_d = 1'b1;
                    end
                    rise_left_d = rise_next;
                    if (rise_next == '0) begin
                        phase_d = P_FALL;
                    end
                end
                P_FALL: begin
                    if (dj_ok) begin
                        y_d         = y_q + Y_W'(1);
                        dj_used_d   = 1'b1;
                        rise_left_d = DJ_RISE_INIT;
                        phase_d     = (DJ_RISE_INIT == '0) ? P_FALL : P_RISE;
                    end else begin
                        y_d = y_q - Y_W'(1);
                        if (y_q == Y_W'(1)) begin
                            phase_d   = P_GROUND;
                            dj_used_d = 1'b0;
                            landed_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean ground state.
                    phase_d     = P_GROUND;
                    y_d         = '0;
                    rise_left_d = '0;
                    dj_used_d   = 1'b0;
                end
            endcase
        end

        airborne_d = (phase_d != P_GROUND);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= P_GROUND;
            y_q         <= '0;
            rise_left_q <= '0;
            dj_used_q   <= 1'b0;
            airborne_q  <= 1'b0;
            landed_q    <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            y_q         <= y_d;
            rise_left_q <= rise_left_d;
            dj_used_q   <= dj_used_d;
            airborne_q  <= airborne_d;
            landed_q    <= landed_d;
        end
    end

    assign y_pos    = y_q;
    assign phase    = phase_q;
    assign airborne = airborne_q;
    assign landed   = landed_q;

endmodule

// File: tb/tb_avatar_motion.sv
// tb_avatar_motion: directed bench for avatar_motion with default parameters.
module tb_avatar_motion;
    import motion_pkg::*;

    logic       clk;
    logic       reset;
    logic       tick;
    logic [1:0] action;
    logic [7:0] x_pos;
    logic [5:0] y_pos;
    logic [1:0] phase;
    logic       airborne;
    logic       landed;

    int n_cmp;
    int n_bad;

    avatar_motion dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .action   (action),
        .x_pos    (x_pos),
        .y_pos    (y_pos),
        .phase    (phase),
        .airborne (airborne),
        .landed   (landed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus and settle just after the edge.
    task automatic step(input logic [1:0] a, input logic t);
        action = a;
        tick   = t;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(A_RUN, 1'b1);
        n_cmp++; if (x_pos !== 8'd0) begin n_bad++; $display("FAIL reset_x: got %0d expected 0", x_pos); end
        n_cmp++; if (y_pos !== 6'd0) begin n_bad++; $display("FAIL reset_y: got %0d expected 0", y_pos); end
        n_cmp++; if (phase !== 2'b00) begin n_bad++; $display("FAIL reset_phase: got %0d expected 0", phase); end
        n_cmp++; if (airborne !== 1'b0) begin n_bad++; $display("FAIL reset_airborne: got %0b expected 0", airborne); end
        n_cmp++; if (landed !== 1'b0) begin n_bad++; $display("FAIL reset_landed: got %0b expected 0", landed); end
        reset = 1'b0;
    endtask

    task automatic test_run();
        for (int k = 1; k <= 5; k++) begin
            step(A_RUN, 1'b1);
            n_cmp++; if (x_pos !== 8'(k)) begin n_bad++; $display("FAIL run_x[%0d]: got %0d expected %0d", k, x_pos, k); end
        end
        n_cmp++; if (y_pos !== 6'd0) begin n_bad++; $display("FAIL run_y: got %0d expected 0", y_pos); end
        n_cmp++; if (phase !== 2'b00) begin n_bad++; $display("FAIL run_phase: got %0d expected 0", phase); end
        n_cmp++; if (airborne !== 1'b0) begin n_bad++; $display("FAIL run_airborne: got %0b expected 0", airborne); end
    endtask

    // Plain 16-tick arc; jump_every holds JUMP on every tick to show it is ignored aloft.
    task automatic test_normal_jump(input bit jump_every);
        logic [1:0] a;
        int ey;
        for (int k = 1; k <= 16; k++) begin
            a = (k == 1 || jump_every) ? A_JUMP : A_STAND;
            step(a, 1'b1);
            ey = (k <= 8) ? k : 16 - k;
            n_cmp++; if (int'(y_pos) !== ey) begin n_bad++; $display("FAIL jump_y[%0d]: got %0d expected %0d", k, y_pos, ey); end
            n_cmp++; if (landed !== (k == 16)) begin n_bad++; $display("FAIL jump_landed[%0d]: got %0b expected %0b", k, landed, k == 16); end
            n_cmp++; if (airborne !== (k < 16)) begin n_bad++; $display("FAIL jump_airborne[%0d]: got %0b expected %0b", k, airborne, k < 16); end
            if (k == 7) begin
                n_cmp++; if (phase !== 2'b01) begin n_bad++; $display("FAIL jump_phase_rise: got %0d expected 1", phase); end
            end
            if (k == 8) begin
                n_cmp++; if (phase !== 2'b10) begin n_bad++; $display("FAIL jump_phase_fall: got %0d expected 2", phase); end
            end
        end
        n_cmp++; if (phase !== 2'b00) begin n_bad++; $display("FAIL jump_phase_ground: got %0d expected 0", phase); end
        step(A_STAND, 1'b0);
        n_cmp++; if (landed !== 1'b0) begin n_bad++; $display("FAIL jump_landed_clear: got %0b expected 0", landed); end
    endtask

    // DJUMP on tick 3; when second_dj is set, another DJUMP on tick 5 must be ignored.
    task automatic test_double_jump_rise(input bit second_dj);
        logic [1:0] a;
        int ey;
        for (int k = 1; k <= 24; k++) begin
            if (k == 1) a = A_JUMP;
            else if (k == 3 || (k == 5 && second_dj)) a = A_DJUMP;
            else a = A_STAND;
            step(a, 1'b1);
            ey = (k <= 12) ? k : 24 - k;
            n_cmp++; if (int'(y_pos) !== ey) begin n_bad++; $display("FAIL dj_y[%0d]: got %0d expected %0d", k, y_pos, ey); end
            if (k == 12) begin
                n_cmp++; if (phase !== 2'b10) begin n_bad++; $display("FAIL dj_phase_peak: got %0d expected 2", phase); end
            end
        end
        n_cmp++; if (landed !== 1'b1) begin n_bad++; $display("FAIL dj_landed: got %0b expected 1", landed); end
        n_cmp++; if (phase !== 2'b00) begin n_bad++; $display("FAIL dj_phase_ground: got %0d expected 0", phase); end
    endtask

    task automatic test_djump_on_ground();
        step(A_DJUMP, 1'b1);
        n_cmp++; if (x_pos !== 8'd5) begin n_bad++; $display("FAIL gnd_dj_x: got %0d expected 5", x_pos); end
        n_cmp++; if (y_pos !== 6'd0) begin n_bad++; $display("FAIL gnd_dj_y: got %0d expected 0", y_pos); end
        n_cmp++; if (phase !== 2'b00) begin n_bad++; $display("FAIL gnd_dj_phase: got %0d expected 0", phase); end
    endtask

    task automatic test_djump_from_fall();
        logic [1:0] a;
        int ey;
        for (int k = 1; k <= 24; k++) begin
            if (k == 1) a = A_JUMP;
            else if (k == 11) a = A_DJUMP;
            else a = A_STAND;
            step(a, 1'b1);
            if (k <= 8) ey = k;
            else if (k <= 10) ey = 16 - k;
            else if (k <= 14) ey = k - 4;
            else ey = 24 - k;
            n_cmp++; if (int'(y_pos) !== ey) begin n_bad++; $display("FAIL fall_dj_y[%0d]: got %0d expected %0d", k, y_pos, ey); end
            if (k == 11) begin
                n_cmp++; if (phase !== 2'b01) begin n_bad++; $display("FAIL fall_dj_phase_rise: got %0d expected 1", phase); end
            end
            if (k == 14) begin
                n_cmp++; if (phase !== 2'b10) begin n_bad++; $display("FAIL fall_dj_phase_fall: got %0d expected 2", phase); end
            end
        end
        n_cmp++; if (landed !== 1'b1) begin n_bad++; $display("FAIL fall_dj_landed: got %0b expected 1", landed); end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 154; k++) step(A_RUN, 1'b1);
        n_cmp++; if (x_pos !== 8'd159) begin n_bad++; $display("FAIL wrap_top: got %0d expected 159", x_pos); end
        step(A_RUN, 1'b1);
        n_cmp++; if (x_pos !== 8'd0) begin n_bad++; $display("FAIL wrap_zero: got %0d expected 0", x_pos); end
    endtask

    task automatic test_run_airborne();
        step(A_JUMP, 1'b1);
        n_cmp++; if (x_pos !== 8'd0 || y_pos !== 6'd1) begin n_bad++; $display("FAIL air_run_start: got x=%0d y=%0d expected x=0 y=1", x_pos, y_pos); end
        for (int k = 1; k <= 4; k++) begin
            step(A_RUN, 1'b1);
            n_cmp++; if (x_pos !== 8'(k) || y_pos !== 6'(k + 1)) begin n_bad++; $display("FAIL air_run[%0d]: got x=%0d y=%0d expected x=%0d y=%0d", k, x_pos, y_pos, k, k + 1); end
        end
        n_cmp++; if (phase !== 2'b01) begin n_bad++; $display("FAIL air_run_phase: got %0d expected 1", phase); end
    endtask

    task automatic test_reset_midair();
        reset = 1'b1;
        step(A_STAND, 1'b1);
        n_cmp++; if (y_pos !== 6'd0) begin n_bad++; $display("FAIL midair_reset_y: got %0d expected 0", y_pos); end
        n_cmp++; if (phase !== 2'b00) begin n_bad++; $display("FAIL midair_reset_phase: got %0d expected 0", phase); end
        n_cmp++; if (landed !== 1'b0) begin n_bad++; $display("FAIL midair_reset_landed: got %0b expected 0", landed); end
        n_cmp++; if (airborne !== 1'b0) begin n_bad++; $display("FAIL midair_reset_airborne: got %0b expected 0", airborne); end
        n_cmp++; if (x_pos !== 8'd0) begin n_bad++; $display("FAIL midair_reset_x: got %0d expected 0", x_pos); end
        reset = 1'b0;
        step(A_STAND, 1'b1);
        n_cmp++; if (landed !== 1'b0 || y_pos !== 6'd0) begin n_bad++; $display("FAIL midair_after: got landed=%0b y=%0d expected 0 0", landed, y_pos); end
    endtask

    task automatic test_tick_hold();
        for (int k = 0; k < 3; k++) step(A_RUN, 1'b1);
        step(A_JUMP, 1'b1);
        n_cmp++; if (x_pos !== 8'd3 || y_pos !== 6'd1) begin n_bad++; $display("FAIL hold_start: got x=%0d y=%0d expected x=3 y=1", x_pos, y_pos); end
        for (int k = 0; k < 10; k++) begin
            step(A_RUN, 1'b0);
            n_cmp++; if (x_pos !== 8'd3 || y_pos !== 6'd1 || phase !== 2'b01) begin n_bad++; $display("FAIL hold[%0d]: got x=%0d y=%0d ph=%0d expected x=3 y=1 ph=1", k, x_pos, y_pos, phase); end
        end
        step(A_STAND, 1'b1);
        n_cmp++; if (y_pos !== 6'd2 || x_pos !== 8'd3) begin n_bad++; $display("FAIL hold_resume: got x=%0d y=%0d expected x=3 y=2", x_pos, y_pos); end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        reset  = 1'b1;
        tick   = 1'b0;
        action = A_STAND;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_run();
        test_normal_jump(1'b0);
        test_double_jump_rise(1'b0);
        test_djump_on_ground();
        test_normal_jump(1'b1);
        test_double_jump_rise(1'b1);
        test_djump_from_fall();
        test_wrap();
        test_run_airborne();
        test_reset_midair();
        test_tick_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
